// File: rtl/ped_xing.sv
// Pedestrian crossing controller.
// Synchronizes and debounces a push-button, requests a vehicle stop from the
// traffic-light controller, then runs WALK and flashing-hand phases while the
// vehicle lamps show red. Leaving red during WALK/FLASH aborts the crossing.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   btn             raw push-button (asynchronous, bouncy)
//   r, y, g         vehicle lamp states (synchronous to clk)
//   ped             request level to the traffic-light controller
//   walk, dont_walk pedestrian lamps
//   flash           high while the hand flashes
//   countdown       remaining flash cycles, 0 outside FLASH
//   req_lamp        request pending / being served indicator
//   fault           one-cycle pulse on an aborted walk
module ped_xing #(
  parameter int unsigned DB = 4,
  parameter int unsigned WT = 2,
  parameter int unsigned FT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  input  logic       r,
  input  logic       y,
  input  logic       g,
  output logic       ped,
  output logic       walk,
  output logic       dont_walk,
  output logic       flash,
  output logic [3:0] countdown,
  output logic       req_lamp,
  output logic       fault
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned CD_W  = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAITR,
    S_WALK,
    S_FLASH
  } state_t;

  state_t             state_q, state_d;
  logic               sync1_q, sync2_q;
  logic               btn_db_q, btn_db_d;
  logic               btn_db_prev_q;
  logic [CNT_W-1:0]   db_cnt_q, db_cnt_d;
  logic [CNT_W-1:0]   timer_q, timer_d;
  logic               pend_q, pend_d;
  logic               press;
  logic               red;

  logic               ped_q, ped_d;
  logic               walk_q, walk_d;
  logic               dont_walk_q, dont_walk_d;
  logic               flash_q, flash_d;
  logic [CD_W-1:0]    countdown_q, countdown_d;
  logic               req_lamp_q, req_lamp_d;
  logic               fault_q, fault_d;

  // State, input conditioning and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      btn_db_q      <= 1'b0;
      btn_db_prev_q <= 1'b0;
      db_cnt_q      <= '0;
      timer_q       <= '0;
      pend_q        <= 1'b0;
      ped_q         <= 1'b0;
      walk_q        <= 1'b0;
      dont_walk_q   <= 1'b1;
      flash_q       <= 1'b0;
      countdown_q   <= '0;
      req_lamp_q    <= 1'b0;
      fault_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= btn;
      sync2_q       <= sync1_q;
      btn_db_q      <= btn_db_d;
      btn_db_prev_q <= btn_db_q;
      db_cnt_q      <= db_cnt_d;
      timer_q       <= timer_d;
      pend_q        <= pend_d;
      ped_q         <= ped_d;
      walk_q        <= walk_d;
      dont_walk_q   <= dont_walk_d;
      flash_q       <= flash_d;
      countdown_q   <= countdown_d;
      req_lamp_q    <= req_lamp_d;
      fault_q       <= fault_d;
    end
  end

  // Debounce, next-state and output decode
  always_comb begin
    btn_db_d    = btn_db_q;
    db_cnt_d    = '0;
    state_d     = state_q;
    timer_d     = timer_q;
    pend_d      = pend_q;
    fault_d     = 1'b0;

    // Accept the synchronized level only after DB consecutive mismatches
    if (sync2_q != btn_db_q) begin
      if (db_cnt_q == CNT_W'(DB - 1)) begin
        btn_db_d = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end

    press = btn_db_q & ~btn_db_prev_q;
    red   = r & ~y & ~g;

    case (state_q)
      S_IDLE: begin
        if (press || pend_q) begin
          state_d = S_REQ;
          pend_d  = 1'b0;
        end
      end
      S_REQ: begin
        if (y) state_d = S_WAITR;
      end
      S_WAITR: begin
        if (red) begin
          state_d = S_WALK;
          timer_d = '0;
        end
      end
      S_WALK, S_FLASH: begin
        if (press) pend_d = 1'b1;
        // Losing red overrides the phase timers
        if (!red) begin
          state_d = S_IDLE;
          timer_d = '0;
          fault_d = 1'b1;
        end else if (state_q == S_WALK && timer_q == CNT_W'(WT - 1)) begin
          state_d = S_FLASH;
          timer_d = '0;
        end else if (state_q == S_FLASH && timer_q == CNT_W'(FT - 1)) begin
          state_d = S_IDLE;
          timer_d = '0;
        end else begin
          timer_d = timer_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        timer_d = '0;
      end
    endcase

    // Outputs decoded from the next state so the registers track it exactly
    ped_d       = (state_d == S_REQ);
    walk_d      = (state_d == S_WALK);
    flash_d     = (state_d == S_FLASH);
    req_lamp_d  = (state_d == S_REQ) || (state_d == S_WAITR) || (state_d == S_WALK);
    countdown_d = flash_d ? (CD_W'(FT) - timer_d[CD_W-1:0]) : '0;
    // Hand toggles during FLASH, starting lit on the first cycle
    dont_walk_d = walk_d ? 1'b0 : (flash_d ? ~timer_d[0] : 1'b1);
  end

  assign ped       = ped_q;
  assign walk      = walk_q;
  assign dont_walk = dont_walk_q;
  assign flash     = flash_q;
  assign countdown = countdown_q;
  assign req_lamp  = req_lamp_q;
  assign fault     = fault_q;

endmodule

// File: tb/tb_ped_xing.sv
// Bench for ped_xing: directed scenarios plus randomized button/lamp traffic,
// all outputs compared every cycle against a phase-level reference model.
module tb_ped_xing;

  localparam int unsigned DB = 4;
  localparam int unsigned WT = 2;
  localparam int unsigned FT = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       r, y, g;
  logic       ped, walk, dont_walk, flash, req_lamp, fault;
  logic [3:0] countdown;

  int n_total = 0;
  int n_bad   = 0;

  ped_xing #(.DB(DB), .WT(WT), .FT(FT)) dut (
    .clk(clk), .rst(rst), .btn(btn), .r(r), .y(y), .g(g),
    .ped(ped), .walk(walk), .dont_walk(dont_walk), .flash(flash),
    .countdown(countdown), .req_lamp(req_lamp), .fault(fault)
  );

  always #5 clk = ~clk;

  // Reference model: pedestrian phase by name, cycles spent in the phase
  bit    m_s1, m_s2, m_db, m_dbp, m_pend, m_fault;
  int    m_run, m_el;
  string m_mode;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_db = 0; m_dbp = 0; m_pend = 0; m_fault = 0;
    m_run = 0; m_el = 0; m_mode = "IDLE";
  endtask

  task automatic model_step();
    bit press, red;
    press   = m_db && !m_dbp;
    red     = r && !y && !g;
    m_fault = 0;
    m_dbp   = m_db;
    if (m_s2 != m_db) begin
      m_run++;
      if (m_run == int'(DB)) begin
        m_db  = m_s2;
        m_run = 0;
      end
    end else begin
      m_run = 0;
    end
    m_s2 = m_s1;
    m_s1 = btn;
    if (m_mode == "IDLE") begin
      if (press || m_pend) begin m_mode = "REQ"; m_pend = 0; end
    end else if (m_mode == "REQ") begin
      if (y) m_mode = "WAITR";
    end else if (m_mode == "WAITR") begin
      if (red) begin m_mode = "WALK"; m_el = 0; end
    end else begin
      if (press) m_pend = 1;
      if (!red) begin
        m_mode = "IDLE"; m_fault = 1; m_el = 0;
      end else begin
        m_el++;
        if (m_mode == "WALK" && m_el == int'(WT)) begin
          m_mode = "FLASH"; m_el = 0;
        end else if (m_mode == "FLASH" && m_el == int'(FT)) begin
          m_mode = "IDLE"; m_el = 0;
        end
      end
    end
  endtask

  task automatic compare_all();
    bit e_walk, e_flash, e_dw;
    int e_cd;
    e_walk  = (m_mode == "WALK");
    e_flash = (m_mode == "FLASH");
    e_cd    = e_flash ? int'(FT) - m_el : 0;
    e_dw    = e_walk ? 1'b0 : (e_flash ? (m_el % 2 == 0) : 1'b1);
    check("ped", int'(ped), int'(m_mode == "REQ"));
    check("walk", int'(walk), int'(e_walk));
    check("flash", int'(flash), int'(e_flash));
    check("dont_walk", int'(dont_walk), int'(e_dw));
    check("countdown", int'(countdown), e_cd);
    check("req_lamp", int'(req_lamp),
          int'(m_mode == "REQ" || m_mode == "WAITR" || m_mode == "WALK"));
    check("fault", int'(fault), int'(m_fault));
    check("walk_and_hand", int'(walk && dont_walk), 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else model_step();
    #1;
    compare_all();
  endtask

  // 0 red, 1 yellow, 2 green, 3 all off, 4 multi-hot
  task automatic set_lamps(input int k);
    case (k)
      0: begin r = 1; y = 0; g = 0; end
      1: begin r = 0; y = 1; g = 0; end
      2: begin r = 0; y = 0; g = 1; end
      3: begin r = 0; y = 0; g = 0; end
      default: begin r = 1; y = 0; g = 1; end
    endcase
  endtask

  task automatic wait_mode(input string m, input int budget);
    int n;
    n = 0;
    while (m_mode != m && n < budget) begin
      tick();
      n++;
    end
    if (m_mode != m) check({"timeout_", m}, 0, 1);
  endtask

  task automatic press_latency(input string tag);
    int first;
    first = -1;
    for (int k = 1; k <= 15; k++) begin
      tick();
      if (ped && first < 0) first = k;
    end
    check(tag, first, 7);
  endtask

  initial begin
    int nwalk, nflash, lf, pr, btn_hold, lamp_hold, w;

    rst = 1; btn = 0; set_lamps(0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    rst = 0;

    // Press latency from a held button
    btn = 1;
    press_latency("ped_latency");
    btn = 0;

    // Full cycle from REQ: green, yellow, then red
    nwalk = 0; nflash = 0;
    set_lamps(2); repeat (3) tick();
    set_lamps(1); repeat (3) tick();
    set_lamps(0);
    for (int k = 0; k < 10; k++) begin
      tick();
      if (walk) nwalk++;
      if (flash) nflash++;
    end
    check("walk_cycles", nwalk, int'(WT));
    check("flash_cycles", nflash, int'(FT));

    // Bouncing button never yields a request
    nwalk = 0;
    for (int k = 0; k < 20; k++) begin
      btn = ~btn;
      tick();
      if (ped) nwalk++;
    end
    btn = 0;
    repeat (8) tick();
    check("bounce_ped", nwalk, 0);

    // Abort during WALK
    btn = 1;
    wait_mode("REQ", 20);
    btn = 0;
    set_lamps(1); tick();
    set_lamps(0);
    wait_mode("WALK", 10);
    set_lamps(2); tick();
    check("abort_fault", int'(fault), 1);
    check("abort_walk", int'(walk), 0);
    set_lamps(0); tick();
    check("abort_fault_clear", int'(fault), 0);

    // Debounced press landing in FLASH is served after one IDLE cycle
    btn = 1;
    wait_mode("REQ", 20);
    btn = 0;
    repeat (8) tick();
    set_lamps(1); tick();
    btn = 1;
    repeat (3) tick();
    set_lamps(0);
    lf = -1; pr = -1;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (flash) lf = k;
      if (ped && lf >= 0 && pr < 0) pr = k;
    end
    check("pend_gap", pr - lf, 2);
    btn = 0;

    // Asynchronous reset in the middle of FLASH
    set_lamps(1); tick();
    set_lamps(0);
    wait_mode("FLASH", 10);
    #3 rst = 1;
    #1;
    check("rst_flash", int'(flash), 0);
    check("rst_walk", int'(walk), 0);
    check("rst_countdown", int'(countdown), 0);
    check("rst_dont_walk", int'(dont_walk), 1);
    check("rst_fault", int'(fault), 0);
    model_reset();
    tick();

    // Button held through reset still produces a press
    btn = 1;
    tick();
    rst = 0;
    press_latency("ped_after_rst");

    // Randomized traffic
    btn_hold = 0; lamp_hold = 0;
    for (int k = 0; k < 4000; k++) begin
      if (btn_hold == 0) begin
        btn = 1'($urandom_range(0, 1));
        btn_hold = $urandom_range(1, 12);
      end else begin
        btn_hold--;
      end
      if (lamp_hold == 0) begin
        w = $urandom_range(0, 9);
        set_lamps(w < 5 ? 0 : (w < 7 ? 1 : (w < 9 ? 2 : (w == 9 ? 3 + $urandom_range(0, 1) : 0))));
        lamp_hold = $urandom_range(1, 8);
      end else begin
        lamp_hold--;
      end
      if ($urandom_range(0, 999) == 0) begin
        rst = 1;
        model_reset();
        tick();
        rst = 0;
      end else begin
        tick();
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
